// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// Bundles the MEM-stage access bus and the responder status outputs.
//   master : drives dir_mem, data, mem_wr, mem_rd, final_mem;
//            observes mem_out, mem_out_valid, burst_done, beat_count, addr_err
//   slave  : the mirror image, used by mem_responder
// Parameters ADDR_W / DATA_W must match the mem_responder instance.
// -----------------------------------------------------------------------------
interface mem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [31:0]       dir_mem;
    logic [DATA_W-1:0] data;
    logic              mem_wr;
    logic              mem_rd;
    logic [31:0]       final_mem;
    logic [DATA_W-1:0] mem_out;
    logic              mem_out_valid;
    logic              burst_done;
    logic [ADDR_W:0]   beat_count;
    logic              addr_err;

    modport master (
        output dir_mem, data, mem_wr, mem_rd, final_mem,
        input  mem_out, mem_out_valid, burst_done, beat_count, addr_err
    );

    modport slave (
        input  dir_mem, data, mem_wr, mem_rd, final_mem,
        output mem_out, mem_out_valid, burst_done, beat_count, addr_err
    );
endinterface

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Single-port word memory answering MEM-stage accesses, with a small FSM that
// tracks vector bursts (IDLE -> ACTIVE -> DONE) ending at address final_mem.
//
// Ports
//   clk  : single clock, all state on rising edge
//   rst  : synchronous, active-high reset (storage contents are kept)
//   bus  : mem_responder_if.slave
//            dir_mem/data/mem_wr/mem_rd/final_mem in,
//            mem_out/mem_out_valid/burst_done/beat_count/addr_err out
//
// Behaviour summary
//   - one access per cycle; wr+rd together is a write only
//   - read data appears one cycle after the strobe with mem_out_valid=1,
//     mem_out holds otherwise
//   - addresses with any bit above ADDR_W-1 set are out of range: writes are
//     dropped, reads return 0, addr_err is raised the following cycle
//   - beat_count saturates at all-ones and holds while IDLE
//
// Build option
//   MEM_WR_FORWARD_EN : read in the cycle right after a write to the same index
//                       returns the written word from a registered copy
//                       instead of the array.
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [ADDR_W:0] BEAT_ONE = (ADDR_W+1)'(1);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] mem_out_q, mem_out_d;
    logic              mem_out_valid_q, mem_out_valid_d;
    logic [ADDR_W:0]   beat_count_q, beat_count_d;
    logic              addr_err_q, addr_err_d;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    logic [ADDR_W-1:0] idx;
    logic              access;
    logic              is_read;
    logic              wr_en;
    logic              out_of_range;
    logic              hit_final;
    logic [ADDR_W:0]   beat_inc;
    logic [DATA_W-1:0] rd_word;

    // Access decode; final_mem is compared on all 32 bits so an out-of-range
    // address can still close a burst.
    always_comb begin
        idx          = bus.dir_mem[ADDR_W-1:0];
        out_of_range = |bus.dir_mem[31:ADDR_W];
        access       = bus.mem_wr | bus.mem_rd;
        is_read      = bus.mem_rd & ~bus.mem_wr;
        wr_en        = bus.mem_wr & ~out_of_range & ~rst;
        hit_final    = access && (bus.dir_mem == bus.final_mem);
        beat_inc     = (beat_count_q == '1) ? beat_count_q : beat_count_q + BEAT_ONE;
    end

`ifdef MEM_WR_FORWARD_EN
    logic              fwd_valid_q, fwd_valid_d;
    logic [ADDR_W-1:0] fwd_idx_q, fwd_idx_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

    // Registered copy of the last accepted write, valid for one cycle only.
    always_comb begin
        fwd_valid_d = wr_en;
        fwd_idx_d   = wr_en ? idx      : fwd_idx_q;
        fwd_data_d  = wr_en ? bus.data : fwd_data_q;
        rd_word     = (fwd_valid_q && fwd_idx_q == idx) ? fwd_data_q : mem[idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_valid_q <= 1'b0;
        end else begin
            fwd_valid_q <= fwd_valid_d;
        end
        fwd_idx_q  <= fwd_idx_d;
        fwd_data_q <= fwd_data_d;
    end
`else
    always_comb begin
        rd_word = mem[idx];
    end
`endif

    // Next-state and output-register logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d         = state_q;
        beat_count_d    = beat_count_q;
        mem_out_d       = mem_out_q;
        mem_out_valid_d = is_read;
        addr_err_d      = access & out_of_range;

        if (is_read) begin
            mem_out_d = out_of_range ? '0 : rd_word;
        end

        case (state_q)
            IDLE: begin
                if (access) begin
                    beat_count_d = BEAT_ONE;
                    state_d      = hit_final ? DONE : ACTIVE;
                end
            end
            ACTIVE: begin
                if (access) begin
                    beat_count_d = beat_inc;
                    if (hit_final) state_d = DONE;
                end
            end
            DONE: begin
                // A new burst may start in the same cycle the old one reports.
                state_d = IDLE;
                if (access) begin
                    beat_count_d = BEAT_ONE;
                    state_d      = hit_final ? DONE : ACTIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q         <= IDLE;
            mem_out_q       <= '0;
            mem_out_valid_q <= 1'b0;
            beat_count_q    <= '0;
            addr_err_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            mem_out_q       <= mem_out_d;
            mem_out_valid_q <= mem_out_valid_d;
            beat_count_q    <= beat_count_d;
            addr_err_q      <= addr_err_d;
        end
    end

    // NOTE: the storage array has no reset; its contents survive rst and it
    // can map onto RAM macros. Strobes during rst are still blocked by wr_en.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= bus.data;
        end
    end

    assign bus.mem_out       = mem_out_q;
    assign bus.mem_out_valid = mem_out_valid_q;
    assign bus.burst_done    = (state_q == DONE);
    assign bus.beat_count    = beat_count_q;
    assign bus.addr_err      = addr_err_q;
endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Self-checking bench for mem_responder (ADDR_W=8, DATA_W=32): a vector table
// for single-beat behaviour and burst tracking, a read-data scoreboard fed from
// a reference memory model, and hand-written sequences for mid-burst reset and
// beat_count saturation.
// -----------------------------------------------------------------------------
module tb_mem_responder;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam logic [31:0] NOF = 32'h8000_0000; // never matches an access

    logic clk;
    logic rst;

    mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] model_mem [256];
    logic [31:0] sb_q [$];
    logic [31:0] hold_val;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] fin;
        logic        done;
        int          beat;
        logic        err;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, clock it, then check read handshake/data.
    task automatic drive_cycle(input logic wr, input logic rd, input logic [31:0] addr,
                               input logic [31:0] data, input logic [31:0] fin,
                               input logic r);
        logic        read_now;
        logic [31:0] exp;
        rst           = r;
        bus.mem_wr    = wr;
        bus.mem_rd    = rd;
        bus.dir_mem   = addr;
        bus.data      = data;
        bus.final_mem = fin;
        read_now = !r && rd && !wr;
        if (read_now) sb_q.push_back((addr > 32'hFF) ? 32'h0 : model_mem[addr[7:0]]);
        if (!r && wr && addr <= 32'hFF) model_mem[addr[7:0]] = data;
        @(posedge clk);
        #1;
        if (r) hold_val = 32'h0;
        check("mem_out_valid", 64'(bus.mem_out_valid), 64'(read_now));
        if (read_now) begin
            exp = sb_q.pop_front();
            if (bus.mem_out_valid) check("mem_out", 64'(bus.mem_out), 64'(exp));
            hold_val = exp;
        end else begin
            check("mem_out_hold", 64'(bus.mem_out), 64'(hold_val));
        end
    endtask

    task automatic idle(input logic [31:0] fin);
        drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, fin, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        hold_val      = 32'h0;
        rst           = 1'b1;
        bus.mem_wr    = 1'b0;
        bus.mem_rd    = 1'b0;
        bus.dir_mem   = 32'h0;
        bus.data      = 32'h0;
        bus.final_mem = NOF;

        // wr, rd, addr, data, fin, done, beat, err (outputs after the edge)
        vecs.push_back('{1'b1, 1'b0, 32'h3,   32'hA5A5_0001, NOF,    1'b0, 1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h3,   32'h0,         32'h3,  1'b1, 2, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,   32'h0,         NOF,    1'b0, 2, 1'b0});
        for (int i = 0; i < 5; i++)
            vecs.push_back('{1'b1, 1'b0, 32'(i), 32'h100 + 32'(i), 32'h4, (i == 4), i + 1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,   32'h0,         NOF,    1'b0, 5, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,   32'h0,         NOF,    1'b0, 5, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, NOF,    1'b0, 1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'h0,   32'h0,         NOF,    1'b0, 2, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h100, 32'h0,         NOF,    1'b0, 3, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 32'h7,   32'h77,        NOF,    1'b0, 4, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h7,   32'h0,         32'h7,  1'b1, 5, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h3,   32'h0,         32'h3,  1'b1, 1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,   32'h0,         NOF,    1'b0, 1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h9,   32'h1234,      NOF,    1'b0, 1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h9,   32'h0,         32'h109, 1'b0, 2, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h109, 32'h0,         32'h109, 1'b1, 3, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 32'h0,   32'h0,         NOF,    1'b0, 3, 1'b0});

        // Reset state.
        drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, NOF, 1'b1);
        drive_cycle(1'b1, 1'b1, 32'h5, 32'h5555, NOF, 1'b1);
        check("rst_burst_done", 64'(bus.burst_done), 64'd0);
        check("rst_beat_count", 64'(bus.beat_count), 64'd0);
        check("rst_addr_err",   64'(bus.addr_err),   64'd0);

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            drive_cycle(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].fin, 1'b0);
            check($sformatf("v%0d_burst_done", i), 64'(bus.burst_done), 64'(vecs[i].done));
            check($sformatf("v%0d_beat_count", i), 64'(bus.beat_count), 64'(vecs[i].beat));
            check($sformatf("v%0d_addr_err", i),   64'(bus.addr_err),   64'(vecs[i].err));
        end

        // Mid-burst reset: known word at 22, then two beats of a 20..25 burst.
        drive_cycle(1'b1, 1'b0, 32'd22, 32'h2222, 32'd22, 1'b0);
        check("pre_done", 64'(bus.burst_done), 64'd1);
        idle(NOF);
        drive_cycle(1'b1, 1'b0, 32'd20, 32'h2020, 32'd25, 1'b0);
        drive_cycle(1'b1, 1'b0, 32'd21, 32'h2121, 32'd25, 1'b0);
        check("mid_beat_count", 64'(bus.beat_count), 64'd2);
        drive_cycle(1'b1, 1'b0, 32'd22, 32'h9999, 32'd25, 1'b1);
        check("abort_beat_count", 64'(bus.beat_count), 64'd0);
        check("abort_burst_done", 64'(bus.burst_done), 64'd0);
        check("abort_addr_err",   64'(bus.addr_err),   64'd0);
        for (int i = 0; i < 3; i++) begin
            idle(32'd25);
            check("post_abort_done", 64'(bus.burst_done), 64'd0);
            check("post_abort_beat", 64'(bus.beat_count), 64'd0);
        end
        drive_cycle(1'b0, 1'b1, 32'd20, 32'h0, NOF, 1'b0);
        drive_cycle(1'b0, 1'b1, 32'd21, 32'h0, NOF, 1'b0);
        drive_cycle(1'b0, 1'b1, 32'd22, 32'h0, 32'd22, 1'b0);
        idle(NOF);

        // Saturation: beat_count stops at 511 and holds through DONE and IDLE.
        for (int i = 0; i < 520; i++)
            drive_cycle(1'b1, 1'b0, 32'd50, 32'(i), NOF, 1'b0);
        check("sat_beat_count", 64'(bus.beat_count), 64'd511);
        drive_cycle(1'b1, 1'b0, 32'd50, 32'hCAFE, 32'd50, 1'b0);
        check("sat_done", 64'(bus.burst_done), 64'd1);
        check("sat_done_beat", 64'(bus.beat_count), 64'd511);
        idle(NOF);
        idle(NOF);
        check("sat_idle_done", 64'(bus.burst_done), 64'd0);
        check("sat_idle_beat", 64'(bus.beat_count), 64'd511);
        drive_cycle(1'b0, 1'b1, 32'd50, 32'h0, NOF, 1'b0);
        check("restart_beat", 64'(bus.beat_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the internal storage index width (depth 2**ADDR_W words).
REQ-002 Parameter DATA_W, default 32, SHALL set the word width.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 dir_mem  in  32  access address from MEM stage.
REQ-006 data  in  DATA_W  write data.
REQ-007 mem_wr  in  1  write strobe.
REQ-008 mem_rd  in  1  read strobe.
REQ-009 final_mem  in  32  last address of the current vector burst.
REQ-010 mem_out  out  DATA_W  registered read data.
REQ-011 mem_out_valid  out  1  mem_out carries a fresh read result this cycle.
REQ-012 burst_done  out  1  one-cycle pulse on burst completion.
REQ-013 beat_count  out  ADDR_W+1  accesses accepted in the current or last burst.
REQ-014 addr_err  out  1  registered flag, out-of-range access last cycle.

Function
REQ-015 An access SHALL be accepted in any cycle with mem_wr=1 or mem_rd=1; at most one access per cycle.
REQ-016 mem_wr=1 and mem_rd=1 together SHALL be treated as a write only; no read result, one beat counted.
REQ-017 A write SHALL store data at index dir_mem[ADDR_W-1:0] at the same clock edge.
REQ-018 A read SHALL present the word on mem_out with mem_out_valid=1 exactly one cycle after the strobe; mem_out SHALL hold its value while mem_out_valid=0.
REQ-019 Out-of-range = any dir_mem bit above ADDR_W-1 set: write SHALL be suppressed, read SHALL return 0 with mem_out_valid=1, addr_err=1 the following cycle; beat still counted.
REQ-020 FSM states IDLE, ACTIVE, DONE.
REQ-021 IDLE: accepted access -> ACTIVE, beat_count:=1; if that access's dir_mem==final_mem -> DONE instead.
REQ-022 ACTIVE: each accepted access increments beat_count; access with dir_mem==final_mem -> DONE; no access -> stay ACTIVE.
REQ-023 DONE: burst_done=1 for exactly this cycle; next state IDLE, or ACTIVE with beat_count:=1 if an access is accepted in the DONE cycle (DONE again if it also hits final_mem).
REQ-024 beat_count SHALL saturate at 2**(ADDR_W+1)-1 and hold its final value in IDLE until the next burst starts.
REQ-025 final_mem comparison SHALL use the full 32 bits, sampled in the cycle of each access.

Reset
REQ-026 With rst=1 at a clock edge: FSM:=IDLE, mem_out:=0, mem_out_valid:=0, burst_done:=0, beat_count:=0, addr_err:=0; strobes in that cycle SHALL be ignored.
REQ-027 Storage contents SHALL NOT be cleared by reset; rst mid-burst SHALL abort the burst without a burst_done pulse.

Configuration
REQ-028 Macro MEM_WR_FORWARD_EN defined: a read issued the cycle immediately after a write to the same index SHALL return the newly written data (forwarded from a registered copy, independent of the array read path).
REQ-029 MEM_WR_FORWARD_EN undefined: no forwarding path exists; same-index read-after-write SHALL return the stored word (identical value, storage path only), and REQ-016 remains the only read/write conflict rule.

Verification
REQ-030 rst, then write 0xA5A5_0001 to addr 3, read addr 3 -> mem_out=0xA5A5_0001, mem_out_valid=1 one cycle after read strobe.
REQ-031 final_mem=4, writes to addrs 0..4 on consecutive cycles -> burst_done pulses once, cycle after addr-4 write; beat_count=5 and held.
REQ-032 dir_mem=0x0000_0100, mem_wr=1 then read addr 0 -> addr_err=1 one cycle, addr 0 unchanged; read of 0x100 -> mem_out=0, valid=1.
REQ-033 mem_wr=1, mem_rd=1 same cycle at addr 7 -> word stored, mem_out_valid stays 0, beat_count+1.
REQ-034 rst asserted after 2 beats of a 6-beat burst -> no burst_done, beat_count=0, prior writes retained.
REQ-035 MEM_WR_FORWARD_EN defined: write 0x1234 to addr 9 then read addr 9 next cycle -> mem_out=0x1234.
